// File: rtl/wb_req_arbiter.sv
// wb_req_arbiter: two-port round-robin arbiter/sequencer for the CPU side of
// wishbone_manager. Port 0 = instruction fetch, port 1 = load/store.
// The winner's request fields are latched at grant, a one-cycle READ/WRITE
// strobe is issued, the manager's BUSY is tracked to completion, and read data
// is returned with a one-cycle ack to the granted port.
// Optional feature macro: WB_REQ_ARBITER_TIMEOUT_EN (abort after TIMEOUT wait
// cycles with ack+err and zero read data).
module wb_req_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                r0_req,
    input  logic                r0_we,
    input  logic [ADDR_W-1:0]   r0_adr,
    input  logic [DATA_W/8-1:0] r0_sel,
    input  logic [DATA_W-1:0]   r0_wdat,
    output logic [DATA_W-1:0]   r0_rdat,
    output logic                r0_ack,
    output logic                r0_err,
    input  logic                r1_req,
    input  logic                r1_we,
    input  logic [ADDR_W-1:0]   r1_adr,
    input  logic [DATA_W/8-1:0] r1_sel,
    input  logic [DATA_W-1:0]   r1_wdat,
    output logic [DATA_W-1:0]   r1_rdat,
    output logic                r1_ack,
    output logic                r1_err,
    output logic                mgr_read,
    output logic                mgr_write,
    output logic [ADDR_W-1:0]   mgr_adr,
    output logic [DATA_W/8-1:0] mgr_sel,
    output logic [DATA_W-1:0]   mgr_wdat,
    input  logic [DATA_W-1:0]   mgr_rdat,
    input  logic                mgr_busy
);

    localparam int SEL_W = DATA_W / 8;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_ISSUE      = 3'd1,
        ST_WAIT_START = 3'd2,
        ST_WAIT_END   = 3'd3,
        ST_DONE       = 3'd4
    } state_t;

    state_t              state_r,      state_s;
    logic                grant_r,      grant_s;
    logic                last_grant_r, last_grant_s;
    logic                we_r,         we_s;
    logic [ADDR_W-1:0]   adr_r,        adr_s;
    logic [SEL_W-1:0]    sel_r,        sel_s;
    logic [DATA_W-1:0]   wdat_r,       wdat_s;
    logic                mgr_read_r,   mgr_read_s;
    logic                mgr_write_r,  mgr_write_s;
    logic                r0_ack_r,     r0_ack_s;
    logic                r1_ack_r,     r1_ack_s;
    logic [DATA_W-1:0]   r0_rdat_r,    r0_rdat_s;
    logic [DATA_W-1:0]   r1_rdat_r,    r1_rdat_s;
    logic                win_s;
    logic                finish_s;
    logic [DATA_W-1:0]   done_dat_s;

`ifdef WB_REQ_ARBITER_TIMEOUT_EN
    localparam int TMO_W = 16;
    localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT);

    logic [TMO_W-1:0]    tmo_cnt_r,    tmo_cnt_s;
    logic                r0_err_r,     r0_err_s;
    logic                r1_err_r,     r1_err_s;
    logic                tmo_hit_s;
    logic                abort_s;
`endif

    // Round-robin winner: a lone requester wins, a tie goes to the port not granted last.
    always_comb begin
        if (r0_req && r1_req) begin
            win_s = ~last_grant_r;
        end else if (r1_req) begin
            win_s = 1'b1;
        end else begin
            win_s = 1'b0;
        end
    end

    // Next-state and next-register-value logic for the transaction sequencer.
    always_comb begin
        state_s      = state_r;
        grant_s      = grant_r;
        last_grant_s = last_grant_r;
        we_s         = we_r;
        adr_s        = adr_r;
        sel_s        = sel_r;
        wdat_s       = wdat_r;
        mgr_read_s   = 1'b0;
        mgr_write_s  = 1'b0;
        r0_ack_s     = 1'b0;
        r1_ack_s     = 1'b0;
        r0_rdat_s    = r0_rdat_r;
        r1_rdat_s    = r1_rdat_r;
        finish_s     = 1'b0;
        done_dat_s   = mgr_rdat;
`ifdef WB_REQ_ARBITER_TIMEOUT_EN
        tmo_cnt_s    = tmo_cnt_r;
        r0_err_s     = 1'b0;
        r1_err_s     = 1'b0;
        abort_s      = 1'b0;
        tmo_hit_s    = (tmo_cnt_r == (TMO_LIMIT - {{(TMO_W-1){1'b0}}, 1'b1}));
`endif
        case (state_r)
            ST_IDLE: begin
                // No grant while the manager is still finishing an earlier cycle.
                if (!mgr_busy && (r0_req || r1_req)) begin
                    state_s      = ST_ISSUE;
                    grant_s      = win_s;
                    last_grant_s = win_s;
                    if (win_s) begin
                        we_s   = r1_we;
                        adr_s  = r1_adr;
                        sel_s  = r1_sel;
                        wdat_s = r1_wdat;
                    end else begin
                        we_s   = r0_we;
                        adr_s  = r0_adr;
                        sel_s  = r0_sel;
                        wdat_s = r0_wdat;
                    end
                    // Strobe registers so it is high exactly during ISSUE.
                    mgr_read_s  = ~we_s;
                    mgr_write_s = we_s;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                state_s = ST_WAIT_START;
`ifdef WB_REQ_ARBITER_TIMEOUT_EN
                tmo_cnt_s = {TMO_W{1'b0}};
`endif
            end
            ST_WAIT_START: begin
`ifdef WB_REQ_ARBITER_TIMEOUT_EN
                tmo_cnt_s = tmo_cnt_r + {{(TMO_W-1){1'b0}}, 1'b1};
                if (tmo_hit_s) begin
                    abort_s = 1'b1;
                end else
`endif
                if (mgr_busy) begin
                    state_s = ST_WAIT_END;
                end else begin
                    state_s = ST_WAIT_START;
                end
            end
            ST_WAIT_END: begin
`ifdef WB_REQ_ARBITER_TIMEOUT_EN
                tmo_cnt_s = tmo_cnt_r + {{(TMO_W-1){1'b0}}, 1'b1};
                if (tmo_hit_s) begin
                    abort_s = 1'b1;
                end else
`endif
                if (!mgr_busy) begin
                    finish_s = 1'b1;
                end else begin
                    state_s = ST_WAIT_END;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

`ifdef WB_REQ_ARBITER_TIMEOUT_EN
        // An aborted wait completes like a normal one but with zero data and err.
        if (abort_s) begin
            finish_s   = 1'b1;
            done_dat_s = {DATA_W{1'b0}};
            if (grant_r) begin
                r1_err_s = 1'b1;
            end else begin
                r0_err_s = 1'b1;
            end
        end else begin
            done_dat_s = mgr_rdat;
        end
`endif

        // Completion: ack and data go to the granted port only; the other holds.
        if (finish_s) begin
            state_s = ST_DONE;
            if (grant_r) begin
                r1_ack_s  = 1'b1;
                r1_rdat_s = done_dat_s;
            end else begin
                r0_ack_s  = 1'b1;
                r0_rdat_s = done_dat_s;
            end
        end else begin
            done_dat_s = done_dat_s;
        end
    end

    // State and datapath registers; synchronous active-high reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            grant_r      <= 1'b0;
            last_grant_r <= 1'b1;
            we_r         <= 1'b0;
            adr_r        <= {ADDR_W{1'b0}};
            sel_r        <= {SEL_W{1'b0}};
            wdat_r       <= {DATA_W{1'b0}};
            mgr_read_r   <= 1'b0;
            mgr_write_r  <= 1'b0;
            r0_ack_r     <= 1'b0;
            r1_ack_r     <= 1'b0;
            r0_rdat_r    <= {DATA_W{1'b0}};
            r1_rdat_r    <= {DATA_W{1'b0}};
`ifdef WB_REQ_ARBITER_TIMEOUT_EN
            tmo_cnt_r    <= {TMO_W{1'b0}};
            r0_err_r     <= 1'b0;
            r1_err_r     <= 1'b0;
`endif
        end else begin
            state_r      <= state_s;
            grant_r      <= grant_s;
            last_grant_r <= last_grant_s;
            we_r         <= we_s;
            adr_r        <= adr_s;
            sel_r        <= sel_s;
            wdat_r       <= wdat_s;
            mgr_read_r   <= mgr_read_s;
            mgr_write_r  <= mgr_write_s;
            r0_ack_r     <= r0_ack_s;
            r1_ack_r     <= r1_ack_s;
            r0_rdat_r    <= r0_rdat_s;
            r1_rdat_r    <= r1_rdat_s;
`ifdef WB_REQ_ARBITER_TIMEOUT_EN
            tmo_cnt_r    <= tmo_cnt_s;
            r0_err_r     <= r0_err_s;
            r1_err_r     <= r1_err_s;
`endif
        end
    end

    assign mgr_read  = mgr_read_r;
    assign mgr_write = mgr_write_r;
    assign mgr_adr   = adr_r;
    assign mgr_sel   = sel_r;
    assign mgr_wdat  = wdat_r;
    assign r0_ack    = r0_ack_r;
    assign r1_ack    = r1_ack_r;
    assign r0_rdat   = r0_rdat_r;
    assign r1_rdat   = r1_rdat_r;

`ifdef WB_REQ_ARBITER_TIMEOUT_EN
    assign r0_err = r0_err_r;
    assign r1_err = r1_err_r;
`else
    assign r0_err = 1'b0;
    assign r1_err = 1'b0;
`endif

endmodule
